// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for the async FIFO write port.
// One requester owns the port per packet; a stalled owner loses it after STALL_MAX idle cycles.
module fifo_wr_arbiter #(
    parameter int NREQ       = 3,
    parameter int DATA_WIDTH = 41,
    parameter int LEN_WIDTH  = 4,
    parameter int STALL_MAX  = 16
) (
    input  logic                       wclk,
    input  logic                       w_rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       full,
    output logic                       winc,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic [NREQ-1:0]            grant,
    output logic                       busy,
    output logic                       pkt_done,
    output logic                       abort
);
    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NREQ - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [LEN_WIDTH-1:0] len_q, len_nxt;
    logic [LEN_WIDTH-1:0] word_cnt, word_cnt_nxt;
    logic [STALL_W-1:0]   stall_cnt, stall_cnt_nxt;
    logic [NREQ-1:0]      grant_nxt;
    logic                 pkt_done_nxt, abort_nxt;
    logic                 fire;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx, cand;

    logic [DATA_WIDTH-1:0] data_arr [NREQ];
    logic [LEN_WIDTH-1:0]  len_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign len_arr[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        len_nxt       = len_q;
        word_cnt_nxt  = word_cnt;
        stall_cnt_nxt = stall_cnt;
        grant_nxt     = grant;
        pkt_done_nxt  = 1'b0;
        abort_nxt     = 1'b0;
        fire          = 1'b0;
        wdata         = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = XFER;
                    owner_nxt     = pick_idx;
                    len_nxt       = len_arr[pick_idx];
                    word_cnt_nxt  = '0;
                    stall_cnt_nxt = '0;
                    grant_nxt     = to_onehot(pick_idx);
                end
            end
            XFER: begin
                wdata = data_arr[owner];
                if (req_valid[owner]) begin
                    // A full FIFO holds the packet without counting toward the stall limit.
                    stall_cnt_nxt = '0;
                    if (!full) begin
                        fire         = 1'b1;
                        word_cnt_nxt = word_cnt + 1'b1;
                        if (word_cnt == len_q) begin
                            state_nxt    = IDLE;
                            pkt_done_nxt = 1'b1;
                            rr_ptr_nxt   = wrap_inc(owner);
                            grant_nxt    = '0;
                        end
                    end
                end else begin
                    stall_cnt_nxt = stall_cnt + 1'b1;
                    if (stall_cnt == STALL_LAST) begin
                        state_nxt  = IDLE;
                        abort_nxt  = 1'b1;
                        rr_ptr_nxt = wrap_inc(owner);
                        grant_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign winc      = fire && !w_rst;
    assign req_ready = winc ? grant : '0;
    assign busy      = (state == XFER);

    always_ff @(posedge wclk) begin
        if (w_rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            word_cnt  <= '0;
            stall_cnt <= '0;
            grant     <= '0;
            pkt_done  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            word_cnt  <= word_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            grant     <= grant_nxt;
            pkt_done  <= pkt_done_nxt;
            abort     <= abort_nxt;
        end
    end

    // Packet length is only meaningful while an owner is latched, so it carries no reset.
    always_ff @(posedge wclk) begin
        len_q <= len_nxt;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 3;
    localparam int DW        = 41;
    localparam int LW        = 4;
    localparam int STALL_MAX = 16;
    localparam int VW        = 1 + DW + 2*NREQ + 3;

    logic              wclk = 1'b0;
    logic              w_rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              full;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [NREQ-1:0]   grant;
    logic              busy, pkt_done, abort;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STALL_MAX(STALL_MAX)
    ) dut (
        .wclk(wclk), .w_rst(w_rst), .req_valid(req_valid), .req_len(req_len),
        .req_data(req_data), .req_ready(req_ready), .full(full), .winc(winc),
        .wdata(wdata), .grant(grant), .busy(busy), .pkt_done(pkt_done), .abort(abort)
    );

    wire  [VW-1:0] obs_vec = {winc, wdata, req_ready, grant, busy, pkt_done, abort};
    logic [VW-1:0] exp_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level model: current owner (-1 when idle), words still owed, idle streak.
    int   m_owner = -1;
    int   m_left  = 0;
    int   m_stall = 0;
    int   m_rr    = 0;
    logic m_done  = 1'b0;
    logic m_abort = 1'b0;

    task automatic model_eval();
        logic            e_winc;
        logic [DW-1:0]   e_wdata;
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_grant;
        logic            e_busy, e_done, e_abort;
        logic            found;
        int              idx;
        e_winc  = 1'b0;
        e_wdata = '0;
        e_ready = '0;
        e_grant = '0;
        e_busy  = (m_owner >= 0);
        e_done  = m_done;
        e_abort = m_abort;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_wdata = req_data[m_owner*DW +: DW];
        end
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (w_rst) begin
            m_owner = -1;
            m_rr    = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_left  = int'(req_len[idx*LW +: LW]) + 1;
                    m_stall = 0;
                end
            end
        end else if (req_valid[m_owner]) begin
            m_stall = 0;
            if (!full) begin
                e_winc           = 1'b1;
                e_ready[m_owner] = 1'b1;
                m_left           = m_left - 1;
                if (m_left == 0) begin
                    m_done  = 1'b1;
                    m_rr    = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else begin
            m_stall = m_stall + 1;
            if (m_stall == STALL_MAX) begin
                m_abort = 1'b1;
                m_rr    = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        exp_vec = {e_winc, e_wdata, e_ready, e_grant, e_busy, e_done, e_abort};
    endtask

    task automatic drive_edge();
        @(posedge wclk);
        #1;
    endtask

    task automatic sample();
        @(negedge wclk);
        model_eval();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'({$urandom, $urandom});
    endtask

    task automatic set_len(input int i, input int l);
        req_len[i*LW +: LW] = LW'(l);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive_edge();
            rand_data();
            w_rst     = (c < 2);
            req_valid = (c < 2) ? 3'b111 : 3'b000;
            full      = 1'b0;
            sample();
            if (c >= 1) begin
                n_checks++;
                if (obs_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL reset_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
                end
            end
            if (c == 1) begin
                n_checks++;
                if ({winc, req_ready, grant, busy, pkt_done, abort} !== 10'b0) begin
                    n_fail++;
                    $display("FAIL reset_state got=%b exp=0", {winc, req_ready, grant, busy, pkt_done, abort});
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int n_w;
        logic [NREQ-1:0] eg;
        n_w = 0;
        for (int c = 0; c < 10; c++) begin
            drive_edge();
            rand_data();
            req_valid = (c < 8) ? 3'b111 : 3'b000;
            for (int i = 0; i < NREQ; i++) set_len(i, 0);
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rr_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            eg = ((c % 2) == 1 && c < 8) ? (3'b001 << (((c - 1) / 2) % NREQ)) : 3'b000;
            n_checks++;
            if (grant !== eg) begin
                n_fail++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, eg);
            end
            if (winc === 1'b1) n_w++;
        end
        n_checks++;
        if (n_w !== 4) begin
            n_fail++;
            $display("FAIL rr_words got=%0d exp=4", n_w);
        end
    endtask

    task automatic test_single();
        int first_w, n_w, done_at;
        first_w = -1;
        n_w     = 0;
        done_at = -1;
        for (int c = 0; c < 8; c++) begin
            drive_edge();
            rand_data();
            req_valid = (c <= 4) ? 3'b001 : 3'b000;
            set_len(0, 3);
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (winc === 1'b1) begin
                n_w++;
                if (first_w < 0) first_w = c;
            end
            if (pkt_done === 1'b1) done_at = c;
        end
        n_checks++;
        if (first_w !== 1 || n_w !== 4 || done_at !== 5) begin
            n_fail++;
            $display("FAIL single_timing got first=%0d words=%0d done=%0d exp 1/4/5", first_w, n_w, done_at);
        end
    endtask

    task automatic test_full_stall();
        int n_w, n_done, n_abort;
        n_w = 0; n_done = 0; n_abort = 0;
        for (int c = 0; c < 9; c++) begin
            drive_edge();
            rand_data();
            req_valid = (c <= 6) ? 3'b010 : 3'b000;
            set_len(1, 2);
            full = (c >= 2 && c <= 4);
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL full_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (full) begin
                n_checks++;
                if (winc !== 1'b0 || req_ready !== 3'b000) begin
                    n_fail++;
                    $display("FAIL full_block c=%0d got winc=%b ready=%b exp 0", c, winc, req_ready);
                end
            end
            if (winc === 1'b1) n_w++;
            if (pkt_done === 1'b1) n_done++;
            if (abort === 1'b1) n_abort++;
        end
        full = 1'b0;
        n_checks++;
        if (n_w !== 3 || n_done !== 1 || n_abort !== 0) begin
            n_fail++;
            $display("FAIL full_count got w=%0d done=%0d abort=%0d exp 3/1/0", n_w, n_done, n_abort);
        end
    endtask

    task automatic test_abort();
        int n_w, abort_at, n_abort;
        n_w = 0; abort_at = -1; n_abort = 0;
        for (int c = 0; c < 23; c++) begin
            drive_edge();
            rand_data();
            if (c <= 1)                req_valid = 3'b001;
            else if (c == 19 || c == 20) req_valid = 3'b111;
            else                       req_valid = 3'b000;
            if (c <= 1) set_len(0, 3);
            else for (int i = 0; i < NREQ; i++) set_len(i, 0);
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL abort_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (winc === 1'b1 && c <= 18) n_w++;
            if (abort === 1'b1) begin
                n_abort++;
                abort_at = c;
            end
            if (c == 20) begin
                n_checks++;
                if (grant !== 3'b010) begin
                    n_fail++;
                    $display("FAIL abort_next_grant got=%b exp=010", grant);
                end
            end
        end
        n_checks++;
        if (abort_at !== 18 || n_abort !== 1 || n_w !== 1) begin
            n_fail++;
            $display("FAIL abort_timing got at=%0d n=%0d words=%0d exp 18/1/1", abort_at, n_abort, n_w);
        end
    endtask

    task automatic test_resume();
        int n_w, done_at, n_abort;
        n_w = 0; done_at = -1; n_abort = 0;
        for (int c = 0; c < 12; c++) begin
            drive_edge();
            rand_data();
            if (c == 0) begin
                req_valid = 3'b100;
                set_len(2, 3);
            end else if (c <= 9) begin
                req_valid[2] = !(c >= 2 && c <= 6);
                req_valid[0] = $urandom_range(0, 1) == 1;
                req_valid[1] = $urandom_range(0, 1) == 1;
                for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 15));
            end else begin
                req_valid = 3'b000;
            end
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL resume_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (winc === 1'b1) n_w++;
            if (pkt_done === 1'b1) done_at = c;
            if (abort === 1'b1) n_abort++;
        end
        n_checks++;
        if (n_w !== 4 || done_at !== 10 || n_abort !== 0) begin
            n_fail++;
            $display("FAIL resume_count got w=%0d done=%0d abort=%0d exp 4/10/0", n_w, done_at, n_abort);
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 10; c++) begin
            drive_edge();
            rand_data();
            w_rst = (c == 5);
            case (c)
                0:       begin req_valid = 3'b001; set_len(0, 0); end
                3, 4, 5: begin req_valid = 3'b010; set_len(1, 3); end
                6:       begin req_valid = 3'b111; for (int i = 0; i < NREQ; i++) set_len(i, 0); end
                7:       req_valid = 3'b111;
                default: req_valid = 3'b000;
            endcase
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (c == 5) begin
                n_checks++;
                if (winc !== 1'b0 || req_ready !== 3'b000) begin
                    n_fail++;
                    $display("FAIL midrst_winc got winc=%b ready=%b exp 0", winc, req_ready);
                end
            end
            if (c == 6) begin
                n_checks++;
                if ({grant, busy, pkt_done, abort} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL midrst_idle got=%b exp=0", {grant, busy, pkt_done, abort});
                end
            end
            if (c == 7) begin
                n_checks++;
                if (grant !== 3'b001) begin
                    n_fail++;
                    $display("FAIL midrst_rr got=%b exp=001", grant);
                end
            end
        end
    endtask

    task automatic test_random();
        int silence [NREQ];
        int n_done;
        n_done = 0;
        for (int i = 0; i < NREQ; i++) silence[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            rand_data();
            w_rst = ($urandom_range(0, 299) == 0);
            full  = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (silence[i] > 0) begin
                    silence[i]--;
                    req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    silence[i]   = 20;
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 9) < 7);
                end
                set_len(i, $urandom_range(0, 15));
            end
            sample();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_vec c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (pkt_done === 1'b1) n_done++;
        end
        w_rst = 1'b0;
        full  = 1'b0;
        n_checks++;
        if (n_done == 0) begin
            n_fail++;
            $display("FAIL random_progress got=%0d packets exp>0", n_done);
        end
    endtask

    initial begin
        w_rst     = 1'b1;
        req_valid = '0;
        req_len   = '0;
        req_data  = '0;
        full      = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_full_stall();
        test_abort();
        test_resume();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
